seq_detect_ctrl: RTL

Programmable serial-pattern detector controller. It holds the configuration (pattern, length, overlap mode, match limit) and sequences one detection run on the serial input x: start, count matches, stop on the limit or an abort.
Output y is a Mealy match pulse, the same x/clk/y contract as the fixed 3-bit detectors. The reset configuration reproduces the "111" overlapping detector.

---
 rtl/seq_detect_ctrl_if.sv | 29 ++
 rtl/seq_detect_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: configuration, control, serial data and status bundle for the pattern detector
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_limit;
    logic             start;
    logic             abort;
    logic             x;
    logic             y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, start, abort, x,
        input  y, busy, done, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, start, abort, x,
        output y, busy, done, match_cnt
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial-pattern detector with run control, match counting and limit
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detect_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [LEN_W-1:0] P_MAX = LEN_W'(PAT_W);

    state_t           r_state;
    logic [PAT_W-1:0] r_hist;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_fill;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_len_eff;
    logic [PAT_W:0]   w_one_sh;
    logic [PAT_W-1:0] w_mask;
    logic             w_hit;
    logic             w_y;
    logic [LEN_W-1:0] w_fill_inc;
    logic             w_last;

    // Length clamping at load, window compare against the low L pattern bits, and the Mealy match
    always_comb begin
        w_len_eff  = (bus.cfg_len == '0) ? LEN_W'(1) : (bus.cfg_len > P_MAX) ? P_MAX : bus.cfg_len;
        w_one_sh   = (PAT_W+1)'(1) << r_len;
        w_mask     = PAT_W'(w_one_sh - 1'b1);
        w_hit      = ((({r_hist[PAT_W-2:0], bus.x} ^ r_pat) & w_mask) == '0);
        w_y        = rst_n && (r_state == S_RUN) && !bus.abort && (r_fill >= r_len - 1'b1) && w_hit;
        w_fill_inc = (r_fill == P_MAX) ? P_MAX : r_fill + 1'b1;
        w_last     = (r_limit != '0) && (r_cnt + 1'b1 == r_limit);
    end

    assign bus.y         = w_y;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.match_cnt = r_cnt;

    // Control FSM: config latching outside RUN, history/fill tracking, match counting and limit stop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_pat   <= PAT_W'(3'b111);
            r_len   <= LEN_W'(3);
            r_ovl   <= 1'b1;
            r_limit <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (r_state != S_RUN && bus.cfg_we) begin
                r_pat   <= bus.cfg_pattern;
                r_len   <= w_len_eff;
                r_ovl   <= bus.cfg_overlap;
                r_limit <= bus.cfg_limit;
            end
            case (r_state)
                S_RUN: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hist <= {r_hist[PAT_W-2:0], bus.x};
                        r_fill <= (w_y && !r_ovl) ? '0 : w_fill_inc;
                        if (w_y) begin
                            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.start && !bus.abort) begin
                        r_state <= S_RUN;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
